data_mem_ctrl: RTL and testbench

Data-side memory controller that terminates the CPU's `mem_bus` load/store port and drives a word-wide block RAM with byte-lane write enables. It sits directly downstream of the CPU execute/writeback stages:
- Execute dispatches a read or write when `busy` is low.
- Writeback consumes `read_data` once `busy` falls.

The block aligns sub-word accesses, generates lane masks and zero-extends load data. Sign extension stays in the CPU.

---
 rtl/data_mem_ctrl.sv | 149 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: accepts CPU load/store dispatches, drives a word-wide
// block RAM with byte-lane enables, and returns right-aligned zero-extended load data.
module data_mem_ctrl #(
    parameter int DEPTH        = 4096,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     dispatch_read,
    input  logic                     dispatch_write,
    input  logic [31:0]              addr,
    input  logic [1:0]               mem_width,
    input  logic [31:0]              write_data,
    output logic                     busy,
    output logic [31:0]              read_data,
    output logic                     access_err,
    output logic                     bram_en,
    output logic [3:0]               bram_we,
    output logic [$clog2(DEPTH)-1:0] bram_addr,
    output logic [31:0]              bram_din,
    input  logic [31:0]              bram_dout,
    output logic [1:0]               dbg_state
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [32:0] LIMIT  = 33'(DEPTH) << 2;
    localparam logic [2:0]  LAT_M1 = 3'(BRAM_LATENCY - 1);

    localparam logic [1:0] W_BYTE  = 2'd0;
    localparam logic [1:0] W_WORD  = 2'd1;
    localparam logic [1:0] W_DWORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  off_q;
    logic [1:0]  width_q;
    logic [2:0]  cnt_q;

    logic        width_bad;
    logic        misaligned;
    logic        out_of_range;
    logic        accept;
    logic        reject;
    logic        rd_last;
    logic [31:0] shifted;
    logic [31:0] load_val;

    // Handshake: a request is taken only in the cycle busy=0 and exactly one dispatch
    // is high; the CPU holds it until then, and busy=0 again means the result is ready.
    always_comb begin
        width_bad    = (mem_width == 2'd3);
        misaligned   = ((mem_width == W_WORD) && addr[0]) ||
                       ((mem_width == W_DWORD) && (addr[1:0] != 2'b00));
        out_of_range = ({1'b0, addr} >= LIMIT);
        accept       = (state_q == IDLE) && (dispatch_read ^ dispatch_write) &&
                       !width_bad && !misaligned && !out_of_range;
        reject       = (state_q == IDLE) && (dispatch_read || dispatch_write) && !accept;
        rd_last      = (state_q == RD_WAIT) && (cnt_q == LAT_M1);
    end

    // RAM request is combinational so the access lands in the issue cycle itself.
    always_comb begin
        bram_en   = 1'b0;
        bram_we   = 4'b0000;
        bram_addr = '0;
        bram_din  = 32'h0;
        if (accept) begin
            bram_en   = 1'b1;
            bram_addr = addr[AW+1:2];
            if (dispatch_write) begin
                case (mem_width)
                    W_BYTE: begin
                        bram_we  = 4'b0001 << addr[1:0];
                        bram_din = {4{write_data[7:0]}};
                    end
                    W_WORD: begin
                        bram_we  = 4'b0011 << addr[1:0];
                        bram_din = {2{write_data[15:0]}};
                    end
                    default: begin
                        bram_we  = 4'b1111;
                        bram_din = write_data;
                    end
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = dispatch_read ? RD_WAIT : WR_DONE;
                end
            end
            RD_WAIT: begin
                if (rd_last) begin
                    state_d = IDLE;
                end
            end
            WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shifted = bram_dout >> {off_q, 3'b000};
        case (width_q)
            W_BYTE:  load_val = {24'h0, shifted[7:0]};
            W_WORD:  load_val = {16'h0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            read_data  <= 32'h0;
            access_err <= 1'b0;
            off_q      <= 2'b00;
            width_q    <= 2'b00;
            cnt_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            busy       <= (state_d != IDLE);
            access_err <= reject;
            if (accept) begin
                off_q   <= addr[1:0];
                width_q <= mem_width;
                cnt_q   <= 3'd0;
            end else if (state_q == RD_WAIT) begin
                cnt_q <= cnt_q + 3'd1;
            end
            if (rd_last) begin
                read_data <= load_val;
            end
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: behavioural block RAM with fixed read latency,
// hand-computed expected load results, rejection and reset-abort scenarios.
module tb_data_mem_ctrl;

    localparam int DEPTH = 4096;
    localparam int LAT   = 2;
    localparam int AW    = $clog2(DEPTH);

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          dispatch_read = 1'b0;
    logic          dispatch_write = 1'b0;
    logic [31:0]   addr = 32'h0;
    logic [1:0]    mem_width = 2'd0;
    logic [31:0]   write_data = 32'h0;
    logic          busy;
    logic [31:0]   read_data;
    logic          access_err;
    logic          bram_en;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_din;
    logic [31:0]   bram_dout;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    data_mem_ctrl #(.DEPTH(DEPTH), .BRAM_LATENCY(LAT)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .dispatch_read  (dispatch_read),
        .dispatch_write (dispatch_write),
        .addr           (addr),
        .mem_width      (mem_width),
        .write_data     (write_data),
        .busy           (busy),
        .read_data      (read_data),
        .access_err     (access_err),
        .bram_en        (bram_en),
        .bram_we        (bram_we),
        .bram_addr      (bram_addr),
        .bram_din       (bram_din),
        .bram_dout      (bram_dout),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    // behavioural block RAM: data for an enable at cycle T is on bram_dout during T+LAT
    logic        mem_clr = 1'b1;
    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] rd_pipe [0:3];

    always @(posedge clk_in) begin
        if (mem_clr) begin
            for (int w = 0; w < DEPTH; w++) mem[w] <= 32'h0;
        end else if (bram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
            end
            rd_pipe[0] <= mem[bram_addr];
        end
        for (int s = 1; s < 4; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign bram_dout = rd_pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // driver tasks: each starts at posedge+1 of the issue cycle
    task automatic do_write(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d,
                            input logic [3:0] exp_we, input logic [31:0] exp_din);
        dispatch_write = 1'b1;
        addr = a;
        mem_width = w;
        write_data = d;
        #1;
        check("wr_en", {31'h0, bram_en}, 32'h1);
        check("wr_we", {28'h0, bram_we}, {28'h0, exp_we});
        check("wr_din", bram_din, exp_din);
        check("wr_addr", {20'h0, bram_addr}, a >> 2);
        tick();
        dispatch_write = 1'b0;
        check("wr_busy_t1", {31'h0, busy}, 32'h1);
        tick();
        check("wr_busy_t2", {31'h0, busy}, 32'h0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [1:0] w, input logic [31:0] exp);
        int n;
        dispatch_read = 1'b1;
        addr = a;
        mem_width = w;
        #1;
        check("rd_en", {31'h0, bram_en}, 32'h1);
        check("rd_we", {28'h0, bram_we}, 32'h0);
        tick();
        dispatch_read = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        check("rd_busy_cycles", n, LAT);
        check("rd_data", read_data, exp);
    endtask

    task automatic do_reject(input string tag, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [1:0] w, input logic [31:0] prev);
        dispatch_read = rd;
        dispatch_write = wr;
        addr = a;
        mem_width = w;
        write_data = 32'hFFFF_FFFF;
        #1;
        check({tag, "_en"}, {31'h0, bram_en}, 32'h0);
        tick();
        dispatch_read = 1'b0;
        dispatch_write = 1'b0;
        check({tag, "_err"}, {31'h0, access_err}, 32'h1);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_rdata"}, read_data, prev);
        tick();
        check({tag, "_err_clr"}, {31'h0, access_err}, 32'h0);
    endtask

    initial begin
        int n_en;
        int n;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        mem_clr = 1'b0;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_rdata", read_data, 32'h0);
        check("rst_err", {31'h0, access_err}, 32'h0);
        check("rst_en", {31'h0, bram_en}, 32'h0);
        check("rst_we", {28'h0, bram_we}, 32'h0);
        check("rst_addr", {20'h0, bram_addr}, 32'h0);
        check("rst_din", bram_din, 32'h0);
        check("rst_state", {30'h0, dbg_state}, 32'h0);

        do_write(32'h10, 2'd2, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        do_read (32'h10, 2'd2, 32'hDEAD_BEEF);
        do_write(32'h13, 2'd0, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
        do_read (32'h10, 2'd2, 32'hA5AD_BEEF);
        do_read (32'h13, 2'd0, 32'h0000_00A5);
        do_read (32'h11, 2'd0, 32'h0000_00BE);
        do_write(32'h22, 2'd1, 32'hFFFF_1234, 4'b1100, 32'h1234_1234);
        do_read (32'h20, 2'd1, 32'h0000_0000);
        do_read (32'h22, 2'd1, 32'h0000_1234);

        do_reject("rej_wmis", 1'b1, 1'b0, 32'h21, 2'd1, 32'h0000_1234);
        do_reject("rej_dmis", 1'b0, 1'b1, 32'h12, 2'd2, 32'h0000_1234);
        do_reject("rej_both", 1'b1, 1'b1, 32'h10, 2'd2, 32'h0000_1234);
        do_reject("rej_range", 1'b1, 1'b0, 32'h4 * DEPTH, 2'd2, 32'h0000_1234);
        do_reject("rej_w3", 1'b1, 1'b0, 32'h10, 2'd3, 32'h0000_1234);

        // dispatch held every cycle with alternating addresses: accepts at 0,3,6,9
        n_en = 0;
        for (int i = 0; i < 12; i++) begin
            dispatch_read = 1'b1;
            mem_width = 2'd2;
            addr = (i % 2 == 1) ? 32'h20 : 32'h10;
            #1;
            if (bram_en) begin
                n_en++;
                check("b2b_busy_at_en", {31'h0, busy}, 32'h0);
                check("b2b_addr", {20'h0, bram_addr}, (i % 2 == 1) ? 32'h8 : 32'h4);
            end
            tick();
        end
        dispatch_read = 1'b0;
        check("b2b_en_count", n_en, 4);
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        check("b2b_last_rdata", read_data, 32'h1234_0000);

        // reset while a read is waiting on the RAM
        tick();
        dispatch_read = 1'b1;
        addr = 32'h10;
        mem_width = 2'd2;
        tick();
        dispatch_read = 1'b0;
        check("abort_busy_pre", {31'h0, busy}, 32'h1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_rdata", read_data, 32'h0);
        check("abort_state", {30'h0, dbg_state}, 32'h0);
        do_read(32'h13, 2'd0, 32'h0000_00A5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
